mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues data-memory requests for loads/stores, stalls upstream until
// ack or timeout, and registers writeback. Optional macro MEM_STAGE_ALIGN_CHECK_EN rejects unaligned Lw/Sw.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op_i,
  input  logic [31:0] regcData_i,
  input  logic [31:0] storeData_i,
  input  logic        regcWrite_i,
  input  logic [4:0]  regcAddr_i,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [3:0]  memBe,
  output logic [31:0] memWdata,
  input  logic        memAck,
  input  logic [31:0] memRdata,
  output logic        stall,
  output logic [31:0] regcData,
  output logic        regcWrite,
  output logic [4:0]  regcAddr,
  output logic        alignErr,
  output logic        busErr
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [29:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        load_q, load_d;
  logic        byte_q, byte_d;
  logic        sext_q, sext_d;
  logic        wr_q, wr_d;
  logic [4:0]  dest_q, dest_d;
  logic [31:0] regcData_q, regcData_d;
  logic        regcWrite_q, regcWrite_d;
  logic [4:0]  regcAddr_q, regcAddr_d;
  logic        busErr_q, busErr_d;

  logic        is_mem, is_load, is_store, is_byte, is_sext;
  logic        align_fault, start_access, timeout, busy;
  logic [7:0]  rd_byte;
  logic [31:0] load_data;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_sext  = 1'b0;
    unique case (op_i)
      OP_LW:  is_load = 1'b1;
      OP_LB:  begin is_load = 1'b1; is_byte = 1'b1; is_sext = 1'b1; end
      OP_LBU: begin is_load = 1'b1; is_byte = 1'b1; end
      OP_SW:  is_store = 1'b1;
      OP_SB:  begin is_store = 1'b1; is_byte = 1'b1; end
      default: ;
    endcase
    is_mem = is_load | is_store;
  end

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  logic alignErr_q, alignErr_d;
  assign align_fault = is_mem & ~is_byte & (regcData_i[1:0] != 2'b00);
  assign alignErr    = alignErr_q;
`else
  // Word accesses simply drop the low address bits.
  assign align_fault = 1'b0;
  assign alignErr    = 1'b0;
`endif

  assign start_access = (state_q == IDLE) & is_mem & ~align_fault;
  assign timeout      = (cnt_q == 8'hFF);
  assign busy         = (state_q == BUSY) & ~rst;

  always_comb begin
    rd_byte = memRdata[7:0];
    case (off_q)
      2'd0: rd_byte = memRdata[7:0];
      2'd1: rd_byte = memRdata[15:8];
      2'd2: rd_byte = memRdata[23:16];
      2'd3: rd_byte = memRdata[31:24];
      default: ;
    endcase
    if (!byte_q)
      load_data = memRdata;
    else if (sext_q)
      load_data = {{24{rd_byte[7]}}, rd_byte};
    else
      load_data = {24'h0, rd_byte};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    off_d       = off_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    load_d      = load_q;
    byte_d      = byte_q;
    sext_d      = sext_q;
    wr_d        = wr_q;
    dest_d      = dest_q;
    regcData_d  = regcData_q;
    regcWrite_d = regcWrite_q;
    regcAddr_d  = regcAddr_q;
    busErr_d    = 1'b0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    alignErr_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_access) begin
          state_d     = BUSY;
          cnt_d       = 8'd0;
          addr_d      = regcData_i[31:2];
          off_d       = regcData_i[1:0];
          we_d        = is_store;
          load_d      = is_load;
          byte_d      = is_byte;
          sext_d      = is_sext;
          wr_d        = regcWrite_i;
          dest_d      = regcAddr_i;
          be_d        = is_byte ? (4'b0001 << regcData_i[1:0]) : 4'b1111;
          wdata_d     = is_byte ? {4{storeData_i[7:0]}} : storeData_i;
          regcWrite_d = 1'b0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        end else if (align_fault) begin
          alignErr_d  = 1'b1;
          regcWrite_d = 1'b0;
`endif
        end else begin
          regcData_d  = regcData_i;
          regcWrite_d = regcWrite_i;
          regcAddr_d  = regcAddr_i;
        end
      end
      BUSY: begin
        // An ack in the final counted cycle still wins over the timeout.
        if (memAck) begin
          state_d = IDLE;
          if (load_q) begin
            regcData_d  = load_data;
            regcWrite_d = wr_q;
            regcAddr_d  = dest_q;
          end else begin
            regcWrite_d = 1'b0;
          end
        end else if (timeout) begin
          state_d     = IDLE;
          busErr_d    = 1'b1;
          regcWrite_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      addr_q      <= 30'd0;
      off_q       <= 2'd0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      we_q        <= 1'b0;
      load_q      <= 1'b0;
      byte_q      <= 1'b0;
      sext_q      <= 1'b0;
      wr_q        <= 1'b0;
      dest_q      <= 5'd0;
      regcData_q  <= 32'd0;
      regcWrite_q <= 1'b0;
      regcAddr_q  <= 5'd0;
      busErr_q    <= 1'b0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
      alignErr_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      off_q       <= off_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      load_q      <= load_d;
      byte_q      <= byte_d;
      sext_q      <= sext_d;
      wr_q        <= wr_d;
      dest_q      <= dest_d;
      regcData_q  <= regcData_d;
      regcWrite_q <= regcWrite_d;
      regcAddr_q  <= regcAddr_d;
      busErr_q    <= busErr_d;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
      alignErr_q  <= alignErr_d;
`endif
    end
  end

  assign memReq    = busy;
  assign memWe     = busy & we_q;
  assign memAddr   = busy ? {addr_q, 2'b00} : 32'd0;
  assign memBe     = busy ? be_q : 4'd0;
  assign memWdata  = busy ? wdata_q : 32'd0;
  assign stall     = ~rst & (start_access | (busy & ~memAck & ~timeout));
  assign regcData  = regcData_q;
  assign regcWrite = regcWrite_q;
  assign regcAddr  = regcAddr_q;
  assign busErr    = busErr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: forwarding, word/byte stores and loads, timeout, reset abort, alignment.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op_i;
  logic [31:0] regcData_i, storeData_i, memRdata;
  logic        regcWrite_i, memAck;
  logic [4:0]  regcAddr_i;
  logic        memReq, memWe, stall, regcWrite, alignErr, busErr;
  logic [31:0] memAddr, memWdata, regcData;
  logic [3:0]  memBe;
  logic [4:0]  regcAddr;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] LW = 6'b100011, LB = 6'b100000, LBU = 6'b100100;
  localparam logic [5:0] SW = 6'b101011, SB = 6'b101000, NOP = 6'b000000, ORI = 6'b001101;

  mem_stage dut (
    .clk(clk), .rst(rst), .op_i(op_i), .regcData_i(regcData_i), .storeData_i(storeData_i),
    .regcWrite_i(regcWrite_i), .regcAddr_i(regcAddr_i), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memBe(memBe), .memWdata(memWdata), .memAck(memAck), .memRdata(memRdata),
    .stall(stall), .regcData(regcData), .regcWrite(regcWrite), .regcAddr(regcAddr),
    .alignErr(alignErr), .busErr(busErr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic wr, input logic [4:0] dst);
    op_i = op; regcData_i = a; storeData_i = sd; regcWrite_i = wr; regcAddr_i = dst;
  endtask

  // Issue one access, ack it after nwait extra BUSY cycles; ends just after the return edge.
  task automatic access(input logic [5:0] op, input logic [31:0] a, input logic wr,
                        input logic [4:0] dst, input int nwait, input logic [31:0] rd);
    drive(op, a, 32'h0, wr, dst);
    tick();
    drive(NOP, 32'h0, 32'h0, 1'b0, 5'd0);
    repeat (nwait) tick();
    memAck = 1'b1; memRdata = rd;
    tick();
    memAck = 1'b0; memRdata = 32'h0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; memAck = 1'b0; memRdata = 32'h0;
    drive(LW, 32'h40, 32'h0, 1'b1, 5'd2);
    tick(); tick();
    chk("rst_regcData", regcData, 32'h0);
    chk("rst_regcWrite", {31'h0, regcWrite}, 32'h0);
    chk("rst_regcAddr", {27'h0, regcAddr}, 32'h0);
    chk("rst_memReq", {31'h0, memReq}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_busErr", {31'h0, busErr}, 32'h0);
    chk("rst_alignErr", {31'h0, alignErr}, 32'h0);
    rst = 1'b0;

    // forwarding of a non-memory op
    drive(ORI, 32'h1100, 32'h0, 1'b1, 5'd1);
    #1 chk("fwd_stall_in", {31'h0, stall}, 32'h0);
    tick();
    drive(NOP, 32'h0, 32'h0, 1'b0, 5'd0);
    chk("fwd_regcData", regcData, 32'h1100);
    chk("fwd_regcAddr", {27'h0, regcAddr}, 32'd1);
    chk("fwd_regcWrite", {31'h0, regcWrite}, 32'd1);
    chk("fwd_stall_out", {31'h0, stall}, 32'h0);

    // word store, ack in third BUSY cycle; inputs during BUSY must be ignored
    drive(SW, 32'h20, 32'hDEADBEEF, 1'b1, 5'd3);
    #1 chk("sw_stall_idle", {31'h0, stall}, 32'd1);
    chk("sw_req_idle", {31'h0, memReq}, 32'd0);
    tick();
    drive(NOP, 32'h5555, 32'h0, 1'b1, 5'd9);
    #1 chk("sw_req1", {31'h0, memReq}, 32'd1);
    chk("sw_we", {31'h0, memWe}, 32'd1);
    chk("sw_addr", memAddr, 32'h20);
    chk("sw_be", {28'h0, memBe}, 32'hF);
    chk("sw_wdata", memWdata, 32'hDEADBEEF);
    chk("sw_stall1", {31'h0, stall}, 32'd1);
    chk("sw_regcWrite_busy", {31'h0, regcWrite}, 32'd0);
    tick();
    chk("sw_req2", {31'h0, memReq}, 32'd1);
    chk("sw_stall2", {31'h0, stall}, 32'd1);
    tick();
    memAck = 1'b1;
    #1 chk("sw_req3", {31'h0, memReq}, 32'd1);
    chk("sw_stall_ack", {31'h0, stall}, 32'd0);
    chk("sw_addr_ack", memAddr, 32'h20);
    tick();
    memAck = 1'b0;
    chk("sw_req_done", {31'h0, memReq}, 32'd0);
    chk("sw_regcWrite_done", {31'h0, regcWrite}, 32'd0);
    tick();
    drive(NOP, 32'h0, 32'h0, 1'b0, 5'd0);
    chk("post_sw_fwd_data", regcData, 32'h5555);
    chk("post_sw_fwd_addr", {27'h0, regcAddr}, 32'd9);

    // byte and word loads
    access(LB, 32'h23, 1'b1, 5'd5, 0, 32'h80123456);
    chk("lb_neg_data", regcData, 32'hFFFFFF80);
    chk("lb_neg_write", {31'h0, regcWrite}, 32'd1);
    chk("lb_neg_addr", {27'h0, regcAddr}, 32'd5);
    access(LBU, 32'h23, 1'b1, 5'd6, 1, 32'h80123456);
    chk("lbu_data", regcData, 32'h00000080);
    chk("lbu_addr", {27'h0, regcAddr}, 32'd6);
    access(LB, 32'h21, 1'b1, 5'd7, 0, 32'h00007F00);
    chk("lb_pos_data", regcData, 32'h0000007F);
    access(LBU, 32'h22, 1'b1, 5'd8, 0, 32'h00AB0000);
    chk("lbu_b2_data", regcData, 32'h000000AB);
    access(LW, 32'h40, 1'b1, 5'd10, 2, 32'h12345678);
    chk("lw_data", regcData, 32'h12345678);
    chk("lw_write", {31'h0, regcWrite}, 32'd1);
    access(LW, 32'h44, 1'b0, 5'd11, 0, 32'h0BADF00D);
    chk("lw_nowrite", {31'h0, regcWrite}, 32'd0);

    // byte store
    drive(SB, 32'h42, 32'h000000AB, 1'b0, 5'd0);
    tick();
    drive(NOP, 32'h0, 32'h0, 1'b0, 5'd0);
    chk("sb_be", {28'h0, memBe}, 32'h4);
    chk("sb_wdata", memWdata, 32'hABABABAB);
    chk("sb_addr", memAddr, 32'h40);
    chk("sb_we", {31'h0, memWe}, 32'd1);
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    chk("sb_done_req", {31'h0, memReq}, 32'd0);

    // memAck in IDLE is ignored
    drive(ORI, 32'h77, 32'h0, 1'b1, 5'd12);
    memAck = 1'b1; memRdata = 32'hFFFFFFFF;
    #1 chk("idle_ack_stall", {31'h0, stall}, 32'd0);
    tick();
    memAck = 1'b0; memRdata = 32'h0;
    drive(NOP, 32'h0, 32'h0, 1'b0, 5'd0);
    chk("idle_ack_data", regcData, 32'h77);
    chk("idle_ack_req", {31'h0, memReq}, 32'd0);

    // timeout: 256 BUSY cycles without ack
    drive(LW, 32'h80, 32'h0, 1'b1, 5'd13);
    tick();
    drive(NOP, 32'h0, 32'h0, 1'b0, 5'd0);
    for (int i = 1; i <= 256; i++) begin
      chk("to_busErr_early", {31'h0, busErr}, 32'd0);
      chk("to_memReq", {31'h0, memReq}, 32'd1);
      chk("to_stall", {31'h0, stall}, (i == 256) ? 32'd0 : 32'd1);
      tick();
    end
    chk("to_busErr", {31'h0, busErr}, 32'd1);
    chk("to_req_after", {31'h0, memReq}, 32'd0);
    chk("to_regcWrite", {31'h0, regcWrite}, 32'd0);
    tick();
    chk("to_busErr_pulse", {31'h0, busErr}, 32'd0);

    // ack coinciding with the last counted cycle is a success
    drive(LW, 32'h84, 32'h0, 1'b1, 5'd14);
    tick();
    drive(NOP, 32'h0, 32'h0, 1'b0, 5'd0);
    repeat (255) tick();
    memAck = 1'b1; memRdata = 32'hCAFEF00D;
    #1 chk("ack255_stall", {31'h0, stall}, 32'd0);
    tick();
    memAck = 1'b0; memRdata = 32'h0;
    chk("ack255_busErr", {31'h0, busErr}, 32'd0);
    chk("ack255_write", {31'h0, regcWrite}, 32'd1);
    chk("ack255_data", regcData, 32'hCAFEF00D);
    chk("ack255_addr", {27'h0, regcAddr}, 32'd14);

    // reset in the second BUSY cycle aborts the access
    drive(LW, 32'h100, 32'h0, 1'b1, 5'd15);
    tick();
    drive(NOP, 32'h0, 32'h0, 1'b0, 5'd0);
    tick();
    rst = 1'b1; memAck = 1'b1; memRdata = 32'hFFFFFFFF;
    #1 chk("rstb_memReq", {31'h0, memReq}, 32'd0);
    chk("rstb_stall", {31'h0, stall}, 32'd0);
    chk("rstb_memAddr", memAddr, 32'h0);
    tick();
    rst = 1'b0; memAck = 1'b0; memRdata = 32'h0;
    chk("rstb_req_after", {31'h0, memReq}, 32'd0);
    chk("rstb_regcWrite", {31'h0, regcWrite}, 32'd0);
    chk("rstb_busErr", {31'h0, busErr}, 32'd0);
    tick();
    chk("rstb_req_idle", {31'h0, memReq}, 32'd0);
    chk("rstb_regcWrite2", {31'h0, regcWrite}, 32'd0);
    chk("rstb_busErr2", {31'h0, busErr}, 32'd0);

    // misaligned word load
    drive(LW, 32'h22, 32'h0, 1'b1, 5'd16);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    #1 chk("al_stall", {31'h0, stall}, 32'd0);
    tick();
    drive(NOP, 32'h0, 32'h0, 1'b0, 5'd0);
    chk("al_alignErr", {31'h0, alignErr}, 32'd1);
    chk("al_memReq", {31'h0, memReq}, 32'd0);
    chk("al_regcWrite", {31'h0, regcWrite}, 32'd0);
    tick();
    chk("al_alignErr_pulse", {31'h0, alignErr}, 32'd0);
    chk("al_memReq2", {31'h0, memReq}, 32'd0);
`else
    #1 chk("al_stall", {31'h0, stall}, 32'd1);
    tick();
    drive(NOP, 32'h0, 32'h0, 1'b0, 5'd0);
    chk("al_memReq", {31'h0, memReq}, 32'd1);
    chk("al_memAddr", memAddr, 32'h20);
    chk("al_memBe", {28'h0, memBe}, 32'hF);
    chk("al_alignErr", {31'h0, alignErr}, 32'd0);
    memAck = 1'b1; memRdata = 32'h600DCAFE;
    tick();
    memAck = 1'b0; memRdata = 32'h0;
    chk("al_data", regcData, 32'h600DCAFE);
    chk("al_write", {31'h0, regcWrite}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
